// File: rtl/nn_pkg.sv
// Shared types and default dimensions for the output-layer score path.
package nn_pkg;

    localparam int unsigned N_CLASSES = 10;
    localparam int unsigned ACC_W     = 32;
    localparam int unsigned OUT_W     = 16;
    localparam int unsigned SHIFT     = 8;

    typedef logic signed [OUT_W-1:0] score_t;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    // Index register width; at least one bit even for a single class.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/score_collector_if.sv
// Beat input, frame output and release handshake between the final layer,
// the score collector and the argmax stage.
interface score_collector_if #(
    parameter int unsigned N_CLASSES = nn_pkg::N_CLASSES,
    parameter int unsigned ACC_W     = nn_pkg::ACC_W,
    parameter int unsigned OUT_W     = nn_pkg::OUT_W
);
    logic                    in_valid;
    logic signed [ACC_W-1:0] in_acc;
    logic                    in_ready;
    logic signed [OUT_W-1:0] out_data [0:N_CLASSES-1];
    logic                    out_enable;
    logic                    layer_done;
    logic                    sat_flag;

    modport master (
        output in_valid, in_acc, layer_done,
        input  in_ready, out_data, out_enable, sat_flag
    );

    modport slave (
        input  in_valid, in_acc, layer_done,
        output in_ready, out_data, out_enable, sat_flag
    );
endinterface

// File: rtl/score_collector_requant.sv
// Combinational requantiser: arithmetic right shift then reduce to OUT_W bits.
// Define SCORE_SAT_EN to clamp out-of-range values (and flag them); otherwise wrap.
module score_requant #(
    parameter int unsigned ACC_W = 32,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned SHIFT = 8
) (
    input  logic signed [ACC_W-1:0] in_acc,
    output logic signed [OUT_W-1:0] score,
    output logic                    clip
);

    logic signed [ACC_W-1:0] shifted;

    assign shifted = in_acc >>> SHIFT;

`ifdef SCORE_SAT_EN
    // Out of range whenever the bits above the target sign bit differ from the sign.
    logic ovf;

    assign ovf = (shifted[ACC_W-1:OUT_W-1] != {(ACC_W-OUT_W+1){shifted[ACC_W-1]}});

    always_comb begin
        score = shifted[OUT_W-1:0];
        clip  = 1'b0;
        if (ovf) begin
            clip  = 1'b1;
            score = shifted[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                     : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end
`else
    logic unused_hi;

    assign unused_hi = ^shifted;
    assign score     = shifted[OUT_W-1:0];
    assign clip      = 1'b0;
`endif

endmodule

// File: rtl/score_collector.sv
// Assembles N_CLASSES requantised scores into a frame and holds it for the
// argmax stage until layer_done. SCORE_SAT_EN selects clamping in score_requant.
module score_collector #(
    parameter int unsigned N_CLASSES = nn_pkg::N_CLASSES,
    parameter int unsigned ACC_W     = nn_pkg::ACC_W,
    parameter int unsigned OUT_W     = nn_pkg::OUT_W,
    parameter int unsigned SHIFT     = nn_pkg::SHIFT
) (
    input  logic               clk,
    input  logic               reset,
    score_collector_if.slave   bus
);

    localparam int unsigned IDX_W = nn_pkg::idx_width(N_CLASSES);

    nn_pkg::state_e          state_q;
    logic [IDX_W-1:0]        idx_q;
    logic                    in_ready_q;
    logic                    out_enable_q;
    logic                    sat_q;
    logic signed [OUT_W-1:0] data_q [N_CLASSES];

    logic signed [OUT_W-1:0] score_d;
    logic                    clip_d;
    logic                    accept_c;
    logic                    last_c;

    score_requant #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_requant (
        .in_acc (bus.in_acc),
        .score  (score_d),
        .clip   (clip_d)
    );

    assign accept_c = bus.in_valid && (state_q == nn_pkg::COLLECT);
    assign last_c   = (idx_q == IDX_W'(N_CLASSES - 1));

    // Collect/hold controller; all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= nn_pkg::COLLECT;
            idx_q        <= '0;
            in_ready_q   <= 1'b1;
            out_enable_q <= 1'b0;
            sat_q        <= 1'b0;
            for (int i = 0; i < int'(N_CLASSES); i++) begin
                data_q[i] <= '0;
            end
        end else begin
            case (state_q)
                nn_pkg::COLLECT: begin
                    if (accept_c) begin
                        data_q[idx_q] <= score_d;
                        sat_q         <= sat_q | clip_d;
                        if (last_c) begin
                            state_q      <= nn_pkg::HOLD;
                            idx_q        <= '0;
                            in_ready_q   <= 1'b0;
                            out_enable_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                nn_pkg::HOLD: begin
                    // Frame stays frozen; in_valid is ignored until release.
                    if (bus.layer_done) begin
                        state_q      <= nn_pkg::COLLECT;
                        in_ready_q   <= 1'b1;
                        out_enable_q <= 1'b0;
                        sat_q        <= 1'b0;
                    end
                end
                default: begin
                    state_q <= nn_pkg::COLLECT;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_enable = out_enable_q;
    assign bus.sat_flag   = sat_q;
    assign bus.out_data   = data_q;

endmodule

// File: tb/tb_score_collector.sv
// Directed bench for score_collector; expectations follow SCORE_SAT_EN if defined.
module tb_score_collector;
    import nn_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_pass  = 0;
    int   n_total = 0;

    int frame_a [10] = '{0, 0, 5, 85, 0, 10, 0, 0, 0, 0};
    int frame_b [10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, -1};

    always #5 clk = ~clk;

    score_collector_if bus ();

    score_collector dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic signed [31:0] acc);
        bus.in_valid = 1'b1;
        bus.in_acc   = acc;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        bus.in_valid   = 1'b1;
        bus.layer_done = 1'b1;
        bus.in_acc     = 32'h0000_7700;
        tick();
        tick();
        reset          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.layer_done = 1'b0;
        n_total++;
        if ({bus.in_ready, bus.out_enable, bus.sat_flag} !== 3'b100) begin
            $display("FAIL reset_ctrl got %b want 100", {bus.in_ready, bus.out_enable, bus.sat_flag});
        end else n_pass++;
        for (int i = 0; i < 10; i++) begin
            n_total++;
            if (bus.out_data[i] !== 16'sd0) $display("FAIL reset_data[%0d] got %0d want 0", i, bus.out_data[i]);
            else n_pass++;
        end
    endtask

    task automatic test_frame();
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_acc   = 32'(frame_a[i] * 256);
            tick();
            n_total++;
            if (i < 9) begin
                if ({bus.in_ready, bus.out_enable} !== 2'b10)
                    $display("FAIL frame_mid[%0d] ready/enable got %b want 10", i, {bus.in_ready, bus.out_enable});
                else n_pass++;
            end else begin
                if ({bus.in_ready, bus.out_enable} !== 2'b01)
                    $display("FAIL frame_done ready/enable got %b want 01", {bus.in_ready, bus.out_enable});
                else n_pass++;
            end
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_total++;
            if (bus.out_data[i] !== OUT_W'(frame_a[i]))
                $display("FAIL frame_data[%0d] got %0d want %0d", i, bus.out_data[i], frame_a[i]);
            else n_pass++;
        end
        n_total++;
        if (bus.sat_flag !== 1'b0) $display("FAIL frame_sat got %b want 0", bus.sat_flag);
        else n_pass++;
    endtask

    task automatic test_hold();
        bit ok;
        bus.in_valid = 1'b1;
        bus.in_acc   = 32'h1234_5600;
        for (int c = 0; c < 20; c++) begin
            tick();
            ok = 1'b1;
            for (int i = 0; i < 10; i++) if (bus.out_data[i] !== OUT_W'(frame_a[i])) ok = 1'b0;
            n_total++;
            if (!ok || {bus.in_ready, bus.out_enable} !== 2'b01)
                $display("FAIL hold_cycle[%0d] data_ok=%b ready/enable=%b want 1/01", c, ok, {bus.in_ready, bus.out_enable});
            else n_pass++;
        end
        bus.layer_done = 1'b1;
        tick();
        bus.layer_done = 1'b0;
        bus.in_valid   = 1'b0;
        n_total++;
        if ({bus.in_ready, bus.out_enable, bus.sat_flag} !== 3'b100)
            $display("FAIL release_ctrl got %b want 100", {bus.in_ready, bus.out_enable, bus.sat_flag});
        else n_pass++;
        n_total++;
        if (bus.out_data[0] !== 16'sd0 || bus.out_data[3] !== 16'sd85)
            $display("FAIL release_retain got %0d,%0d want 0,85", bus.out_data[0], bus.out_data[3]);
        else n_pass++;
        beat(32'h0000_0300);
        n_total++;
        if (bus.out_data[0] !== 16'sd3 || bus.out_data[1] !== 16'sd0)
            $display("FAIL first_beat_idx0 got %0d,%0d want 3,0", bus.out_data[0], bus.out_data[1]);
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        beat(32'h0000_0100);
        beat(32'h0000_0200);
        beat(32'h0000_0400);
        n_total++;
        if (bus.out_data[3] !== 16'sd4) $display("FAIL partial_beat got %0d want 4", bus.out_data[3]);
        else n_pass++;
        reset          = 1'b1;
        bus.in_valid   = 1'b1;
        bus.layer_done = 1'b1;
        tick();
        reset          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.layer_done = 1'b0;
        n_total++;
        if ({bus.in_ready, bus.out_enable, bus.sat_flag} !== 3'b100)
            $display("FAIL midreset_ctrl got %b want 100", {bus.in_ready, bus.out_enable, bus.sat_flag});
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            n_total++;
            if (bus.out_data[i] !== 16'sd0) $display("FAIL midreset_data[%0d] got %0d want 0", i, bus.out_data[i]);
            else n_pass++;
        end
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_acc   = 32'(frame_b[i] * 256);
            tick();
            if (i == 8) begin
                n_total++;
                if (bus.out_enable !== 1'b0) $display("FAIL refill_early got %b want 0", bus.out_enable);
                else n_pass++;
            end
        end
        bus.in_valid = 1'b0;
        n_total++;
        if ({bus.in_ready, bus.out_enable} !== 2'b01)
            $display("FAIL refill_done got %b want 01", {bus.in_ready, bus.out_enable});
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            n_total++;
            if (bus.out_data[i] !== OUT_W'(frame_b[i]))
                $display("FAIL refill_data[%0d] got %0d want %0d", i, bus.out_data[i], frame_b[i]);
            else n_pass++;
        end
        bus.layer_done = 1'b1;
        tick();
        bus.layer_done = 1'b0;
    endtask

    task automatic test_gaps();
        bus.layer_done = 1'b1;
        tick();
        bus.layer_done = 1'b0;
        n_total++;
        if ({bus.in_ready, bus.out_enable} !== 2'b10)
            $display("FAIL done_in_collect got %b want 10", {bus.in_ready, bus.out_enable});
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            int gap;
            gap = int'($urandom_range(3, 0));
            for (int g = 0; g < gap; g++) begin
                bus.in_valid   = 1'b0;
                bus.in_acc     = $urandom;
                bus.layer_done = (i == 4);
                tick();
            end
            bus.layer_done = 1'b0;
            beat(32'(frame_a[i] * 256));
            if (i < 9) begin
                n_total++;
                if (bus.out_enable !== 1'b0) $display("FAIL gap_early[%0d] got %b want 0", i, bus.out_enable);
                else n_pass++;
            end
        end
        n_total++;
        if ({bus.in_ready, bus.out_enable} !== 2'b01)
            $display("FAIL gap_done got %b want 01", {bus.in_ready, bus.out_enable});
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            n_total++;
            if (bus.out_data[i] !== OUT_W'(frame_a[i]))
                $display("FAIL gap_data[%0d] got %0d want %0d", i, bus.out_data[i], frame_a[i]);
            else n_pass++;
        end
        bus.layer_done = 1'b1;
        tick();
        bus.layer_done = 1'b0;
    endtask

    task automatic test_sat();
        logic signed [15:0] exp0, exp1;
        logic               exp_sat;
`ifdef SCORE_SAT_EN
        exp0 = 16'sh7FFF;
        exp1 = 16'sh8000;
        exp_sat = 1'b1;
`else
        exp0 = 16'shFF00;
        exp1 = 16'sh0000;
        exp_sat = 1'b0;
`endif
        beat(32'h7FFF_0000);
        n_total++;
        if (bus.sat_flag !== exp_sat) $display("FAIL sat_first got %b want %b", bus.sat_flag, exp_sat);
        else n_pass++;
        beat(32'h8000_0000);
        for (int i = 0; i < 8; i++) beat(32'h0000_0100);
        n_total++;
        if (bus.out_enable !== 1'b1) $display("FAIL sat_done got %b want 1", bus.out_enable);
        else n_pass++;
        n_total++;
        if (bus.out_data[0] !== exp0) $display("FAIL sat_pos got %0d want %0d", bus.out_data[0], exp0);
        else n_pass++;
        n_total++;
        if (bus.out_data[1] !== exp1) $display("FAIL sat_neg got %0d want %0d", bus.out_data[1], exp1);
        else n_pass++;
        n_total++;
        if (bus.out_data[2] !== 16'sd1 || bus.sat_flag !== exp_sat)
            $display("FAIL sat_frame got %0d/%b want 1/%b", bus.out_data[2], bus.sat_flag, exp_sat);
        else n_pass++;
        bus.layer_done = 1'b1;
        tick();
        bus.layer_done = 1'b0;
        n_total++;
        if ({bus.in_ready, bus.out_enable, bus.sat_flag} !== 3'b100)
            $display("FAIL sat_release got %b want 100", {bus.in_ready, bus.out_enable, bus.sat_flag});
        else n_pass++;
    endtask

    initial begin
        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.layer_done = 1'b0;
        bus.in_acc     = '0;
        test_reset();
        test_frame();
        test_hold();
        test_reset_midframe();
        test_gaps();
        test_sat();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/score_collector.md
SCORE_COLLECTOR -- requirements
Module: score_collector

Interface
REQ-001 Parameter N_CLASSES, default 10: number of output-layer scores per frame.
REQ-002 Parameter ACC_W, default 32: width of each incoming signed accumulator value.
REQ-003 Parameter OUT_W, default 16: width of each stored signed score.
REQ-004 Parameter SHIFT, default 8: arithmetic right shift applied to each accumulator, range 0..ACC_W-OUT_W.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  1  in_acc carries a valid score this cycle.
REQ-008 in_acc  in  ACC_W signed  final-layer accumulator for the next class index.
REQ-009 in_ready  out  1  block accepts in_acc this cycle.
REQ-010 out_data  out  N_CLASSES x OUT_W signed, unpacked [0:N_CLASSES-1]  assembled score frame for the argmax stage.
REQ-011 out_enable  out  1  out_data is complete and stable; drives the argmax stage enable.
REQ-012 layer_done  in  1  argmax stage has produced its digit; releases the frame.
REQ-013 sat_flag  out  1  at least one score in the current frame was clipped (SCORE_SAT_EN only; else tied 0).

Function
REQ-014 States SHALL be COLLECT and HOLD, one-hot or binary encoded.
REQ-015 In COLLECT, in_ready SHALL be 1 and out_enable 0.
REQ-016 In COLLECT, a beat SHALL be accepted when in_valid=1 and in_ready=1.
REQ-017 An accepted beat SHALL be written to out_data[idx], where idx is the beat count since frame start (0 first), and idx SHALL increment.
REQ-018 Stored value SHALL be in_acc >>> SHIFT (arithmetic), reduced to OUT_W bits per REQ-029/REQ-030.
REQ-019 When the beat at idx=N_CLASSES-1 is accepted, the next cycle SHALL be HOLD with idx=0; no wrap-around writes.
REQ-020 In HOLD, in_ready SHALL be 0, out_enable 1, and out_data SHALL not change; in_valid is ignored.
REQ-021 In HOLD, layer_done=1 SHALL return to COLLECT the next cycle with out_enable=0, sat_flag=0 and out_data retained.
REQ-022 layer_done in COLLECT SHALL be ignored.
REQ-023 Latency from the last accepted beat to out_enable=1 SHALL be exactly 1 cycle.
REQ-024 Accepting beats back-to-back every cycle SHALL be supported; gaps with in_valid=0 SHALL hold idx.
REQ-025 In HOLD, if layer_done and in_valid are both 1, no beat SHALL be accepted in that cycle.

Reset
REQ-026 reset=1 SHALL, at the next edge, force COLLECT, idx=0, out_enable=0, sat_flag=0 and every out_data element to 0; in_ready SHALL read 1 from the next cycle.
REQ-027 reset SHALL take priority over in_valid and layer_done in the same cycle.
REQ-028 reset mid-frame or in HOLD SHALL discard the partial or held frame without further handshakes.

Configuration
REQ-029 With SCORE_SAT_EN defined, shifted values above 2^(OUT_W-1)-1 or below -2^(OUT_W-1) SHALL clamp to those limits, and sat_flag SHALL set sticky for the frame.
REQ-030 Without SCORE_SAT_EN, the stored value SHALL be the low OUT_W bits of the shifted value (two's-complement wrap), and sat_flag SHALL be constant 0.

Structure
REQ-031 N_CLASSES, OUT_W, the score element typedef and the state enum SHALL live in the shared package nn_pkg.
REQ-032 The shift/saturate arithmetic SHALL be a combinational sub-module score_requant (in_acc -> score, clip).

Verification
REQ-033 Ten beats with in_acc = {0,0,5,85,0,10,0,0,0,0} << 8, back-to-back -> out_data equals {0,0,5,85,0,10,0,0,0,0}; out_enable=1 exactly 1 cycle after beat 9; in_ready=0.
REQ-034 HOLD with in_valid held at 1 for 20 cycles, then layer_done pulse -> out_data unchanged throughout; COLLECT the next cycle; the following beat is written to index 0.
REQ-035 With SCORE_SAT_EN, in_acc=0x7FFF_0000 and 0x8000_0000 -> stored 32767 and -32768, sat_flag=1; without the macro -> stored low 16 bits, sat_flag=0.
REQ-036 Reset asserted after 4 beats -> all out_data elements 0, idx=0, and a new 10-beat frame completes normally.
REQ-037 Beats with random in_valid gaps -> same frame contents as the gap-free run; layer_done pulsed in COLLECT has no effect.
